// File: rtl/alpha_blend_pipe.sv
// Pipelined per-channel pixel blender (alpha / additive / multiply) with end-of-frame tracking.
// Additive and multiply modes exist only when ALPHA_BLEND_MODES_EN is defined; otherwise every pixel alpha-blends.
module alpha_blend_pipe #(
    parameter int unsigned CW     = 8,
    parameter int unsigned NCH    = 3,
    parameter int unsigned AW     = 19,
    parameter int unsigned STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pixel_valid,
    output logic              pixel_ready,
    input  logic [AW-1:0]     pixel_number,
    input  logic [NCH*CW-1:0] src,
    input  logic [CW-1:0]     a,
    input  logic [NCH*CW-1:0] dst,
    input  logic [1:0]        mode,
    output logic              write,
    output logic [AW-1:0]     write_addr,
    output logic [NCH*CW-1:0] write_data,
    input  logic              write_ready,
    input  logic              frame_ready,
    output logic              o_frame_ready
);
    localparam int unsigned PW = NCH * CW;
    localparam int unsigned IW = 2 * CW + 1;
    localparam logic [IW-1:0] M    = {{(IW-CW){1'b0}}, {CW{1'b1}}};
    localparam logic [IW-1:0] HALF = M >> 1;

    function automatic logic [CW-1:0] blend_alpha(input logic [CW-1:0] s, input logic [CW-1:0] d,
                                                  input logic [CW-1:0] al);
        logic [IW-1:0] res;
        res = (IW'(d) * (M - IW'(al)) + IW'(s) * IW'(al) + HALF) / M;
        return CW'(res);
    endfunction

`ifdef ALPHA_BLEND_MODES_EN
    function automatic logic [CW-1:0] blend_add(input logic [CW-1:0] s, input logic [CW-1:0] d,
                                                input logic [CW-1:0] al);
        logic [IW-1:0] res;
        res = IW'(d) + (IW'(s) * IW'(al) + HALF) / M;
        if (res > M) res = M;
        return CW'(res);
    endfunction

    function automatic logic [CW-1:0] blend_mul(input logic [CW-1:0] s, input logic [CW-1:0] d);
        logic [IW-1:0] res;
        res = (IW'(s) * IW'(d) + HALF) / M;
        return CW'(res);
    endfunction
`endif

    logic [STAGES-1:0] valid_q, valid_d;
    logic [AW-1:0]     addr_q [STAGES];
    logic [PW-1:0]     data_q [STAGES];
    logic              frame_pending_q, frame_pending_d;
    logic              o_frame_ready_q, o_frame_ready_d;
    logic [PW-1:0]     op_src_q, op_dst_q;
    logic [CW-1:0]     op_a_q;
    logic [PW-1:0]     bl_src_c, bl_dst_c, blend_c;
    logic [CW-1:0]     bl_a_c;
    logic              stall_c, accept_c, pend_in_c;

    assign stall_c     = valid_q[STAGES-1] & ~write_ready;
    assign pixel_ready = ~reset & ~stall_c & ~frame_pending_q;
    assign accept_c    = pixel_valid & pixel_ready;

    // Single-stage builds blend straight from the ports; deeper ones register operands first.
    assign bl_src_c = (STAGES == 1) ? src : op_src_q;
    assign bl_dst_c = (STAGES == 1) ? dst : op_dst_q;
    assign bl_a_c   = (STAGES == 1) ? a   : op_a_q;

`ifdef ALPHA_BLEND_MODES_EN
    logic [1:0] op_mode_q, bl_mode_c;
    assign bl_mode_c = (STAGES == 1) ? mode : op_mode_q;
`else
    logic unused_mode;
    assign unused_mode = ^mode;
`endif

    always_comb begin
        blend_c = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
`ifdef ALPHA_BLEND_MODES_EN
            case (bl_mode_c)
                2'd1:    blend_c[k*CW +: CW] = blend_add(bl_src_c[k*CW +: CW], bl_dst_c[k*CW +: CW], bl_a_c);
                2'd2:    blend_c[k*CW +: CW] = blend_mul(bl_src_c[k*CW +: CW], bl_dst_c[k*CW +: CW]);
                default: blend_c[k*CW +: CW] = blend_alpha(bl_src_c[k*CW +: CW], bl_dst_c[k*CW +: CW], bl_a_c);
            endcase
`else
            blend_c[k*CW +: CW] = blend_alpha(bl_src_c[k*CW +: CW], bl_dst_c[k*CW +: CW], bl_a_c);
`endif
        end
    end

    // Frame event completes once the pipeline will be empty after this edge.
    always_comb begin
        valid_d = valid_q;
        if (!stall_c) begin
            valid_d[0] = accept_c;
            for (int unsigned i = 1; i < STAGES; i++) valid_d[i] = valid_q[i-1];
        end
        pend_in_c       = frame_pending_q | frame_ready;
        o_frame_ready_d = pend_in_c & (valid_d == '0);
        frame_pending_d = pend_in_c & (valid_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q         <= '0;
            frame_pending_q <= 1'b0;
            o_frame_ready_q <= 1'b0;
            op_src_q        <= '0;
            op_dst_q        <= '0;
            op_a_q          <= '0;
`ifdef ALPHA_BLEND_MODES_EN
            op_mode_q       <= '0;
`endif
            for (int unsigned i = 0; i < STAGES; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q         <= valid_d;
            frame_pending_q <= frame_pending_d;
            o_frame_ready_q <= o_frame_ready_d;
            if (!stall_c) begin
                op_src_q  <= src;
                op_dst_q  <= dst;
                op_a_q    <= a;
`ifdef ALPHA_BLEND_MODES_EN
                op_mode_q <= mode;
`endif
                addr_q[0] <= pixel_number;
                data_q[0] <= (STAGES == 1) ? blend_c : '0;
                for (int unsigned i = 1; i < STAGES; i++) begin
                    addr_q[i] <= addr_q[i-1];
                    data_q[i] <= (i == 1) ? blend_c : data_q[i-1];
                end
            end
        end
    end

    assign write         = valid_q[STAGES-1];
    assign write_addr    = addr_q[STAGES-1];
    assign write_data    = data_q[STAGES-1];
    assign o_frame_ready = o_frame_ready_q;

endmodule
